// File: rtl/alarm_ctrl.sv
// alarm_ctrl
//   Alarm controller for the digital clock. Stores a user-settable HH:MM
//   alarm time in BCD, compares it against the running HH:MM:SS time and
//   sequences the alarm through ringing, snooze and timeout phases.
//
// Ports:
//   clk                      system clock
//   rst                      synchronous reset, active-high
//   tick_1s                  one-cycle pulse once per second
//   bcd_H1..bcd_S2           current time, *1 = tens digit, *2 = units digit
//   arm_toggle               key pulse, toggles armed/disarmed
//   snooze_req               key pulse, requests snooze while ringing
//   stop_req                 key pulse, silences the alarm and keeps it armed
//   set_sel                  00 none, 01 edit hours, 10 edit minutes, 11 ignored
//   set_inc                  pulse, increments the selected alarm field
//   alarm_H1..alarm_M2       stored alarm time (BCD)
//   armed                    high in ARMED, RINGING and SNOOZE
//   ringing                  high in RINGING
//   snoozing                 high in SNOOZE
//   buzzer                   1 s on / 1 s off beep while ringing, starting on
module alarm_ctrl #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter logic [7:0]  ALARM_RST_H    = 8'h06,
    parameter logic [7:0]  ALARM_RST_M    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [3:0] bcd_H1,
    input  logic [3:0] bcd_H2,
    input  logic [3:0] bcd_M1,
    input  logic [3:0] bcd_M2,
    input  logic [3:0] bcd_S1,
    input  logic [3:0] bcd_S2,
    input  logic       arm_toggle,
    input  logic       snooze_req,
    input  logic       stop_req,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    output logic [3:0] alarm_H1,
    output logic [3:0] alarm_H2,
    output logic [3:0] alarm_M1,
    output logic [3:0] alarm_M2,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam int unsigned RING_W      = $clog2(RING_TIMEOUT_S);
    localparam int unsigned SNOOZE_LOAD = SNOOZE_MIN * 60;
    localparam int unsigned SNOOZE_W    = $clog2(SNOOZE_LOAD + 1);

    localparam logic [RING_W-1:0]   RING_LAST   = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [SNOOZE_W-1:0] SNOOZE_INIT = SNOOZE_W'(SNOOZE_LOAD);
    localparam logic [SNOOZE_W-1:0] SNOOZE_LAST = SNOOZE_W'(1);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        RINGING,
        SNOOZE
    } state_t;

    state_t              state;
    logic [RING_W-1:0]   ring_cnt;
    logic [SNOOZE_W-1:0] snooze_cnt;
    logic                phase;
    logic                match;
    logic                match_q;
    logic                match_event;

    logic [3:0] hr_next_h1;
    logic [3:0] hr_next_h2;
    logic [3:0] min_next_m1;
    logic [3:0] min_next_m2;

    // ------------------------------------------------------------------
    // Alarm time editing
    // ------------------------------------------------------------------

    // Hours run 00..23 with BCD carry from units into tens.
    always_comb begin
        hr_next_h1 = alarm_H1;
        hr_next_h2 = alarm_H2;
        if (alarm_H1 == 4'd2 && alarm_H2 == 4'd3) begin
            hr_next_h1 = 4'd0;
            hr_next_h2 = 4'd0;
        end else if (alarm_H2 == 4'd9) begin
            hr_next_h1 = alarm_H1 + 4'd1;
            hr_next_h2 = 4'd0;
        end else begin
            hr_next_h2 = alarm_H2 + 4'd1;
        end
    end

    // Minutes run 00..59 and never carry into the hours.
    always_comb begin
        min_next_m1 = alarm_M1;
        min_next_m2 = alarm_M2;
        if (alarm_M2 == 4'd9) begin
            min_next_m2 = 4'd0;
            if (alarm_M1 == 4'd5) begin
                min_next_m1 = 4'd0;
            end else begin
                min_next_m1 = alarm_M1 + 4'd1;
            end
        end else begin
            min_next_m2 = alarm_M2 + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_H1 <= ALARM_RST_H[7:4];
            alarm_H2 <= ALARM_RST_H[3:0];
            alarm_M1 <= ALARM_RST_M[7:4];
            alarm_M2 <= ALARM_RST_M[3:0];
        end else if (set_inc) begin
            case (set_sel)
                2'b01: begin
                    alarm_H1 <= hr_next_h1;
                    alarm_H2 <= hr_next_h2;
                end
                2'b10: begin
                    alarm_M1 <= min_next_m1;
                    alarm_M2 <= min_next_m2;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Match detection
    // ------------------------------------------------------------------

    // Raw 4-bit compare; the rising edge of match gives one event per
    // matching second even though the time stays equal for ~50M cycles.
    always_comb begin
        match = (bcd_H1 == alarm_H1) && (bcd_H2 == alarm_H2) &&
                (bcd_M1 == alarm_M1) && (bcd_M2 == alarm_M2) &&
                (bcd_S1 == 4'd0)     && (bcd_S2 == 4'd0);
        match_event = match && !match_q;
    end

    // ------------------------------------------------------------------
    // Alarm sequencer
    // ------------------------------------------------------------------

    // Status outputs and buzzer are loaded with the values of the state
    // being entered, so they follow the causing input by exactly one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DISARMED;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            phase      <= 1'b0;
            match_q    <= 1'b0;
            armed      <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            match_q <= match;
            case (state)
                DISARMED: begin
                    if (arm_toggle) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end

                ARMED: begin
                    if (arm_toggle) begin
                        state <= DISARMED;
                        armed <= 1'b0;
                    end else if (match_event) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                        phase    <= 1'b1;
                        ringing  <= 1'b1;
                        buzzer   <= 1'b1;
                    end
                end

                RINGING: begin
                    if (arm_toggle) begin
                        state      <= DISARMED;
                        ring_cnt   <= '0;
                        snooze_cnt <= '0;
                        phase      <= 1'b0;
                        armed      <= 1'b0;
                        ringing    <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (stop_req) begin
                        state      <= ARMED;
                        ring_cnt   <= '0;
                        snooze_cnt <= '0;
                        phase      <= 1'b0;
                        ringing    <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (snooze_req) begin
                        state      <= SNOOZE;
                        ring_cnt   <= '0;
                        snooze_cnt <= SNOOZE_INIT;
                        phase      <= 1'b0;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                        buzzer     <= 1'b0;
                    end else if (tick_1s) begin
                        if (ring_cnt == RING_LAST) begin
                            state      <= ARMED;
                            ring_cnt   <= '0;
                            snooze_cnt <= '0;
                            phase      <= 1'b0;
                            ringing    <= 1'b0;
                            buzzer     <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + RING_W'(1);
                            phase    <= ~phase;
                            buzzer   <= ~phase;
                        end
                    end
                end

                SNOOZE: begin
                    if (arm_toggle) begin
                        state      <= DISARMED;
                        ring_cnt   <= '0;
                        snooze_cnt <= '0;
                        phase      <= 1'b0;
                        armed      <= 1'b0;
                        snoozing   <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (stop_req) begin
                        state      <= ARMED;
                        ring_cnt   <= '0;
                        snooze_cnt <= '0;
                        phase      <= 1'b0;
                        snoozing   <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (tick_1s) begin
                        // snooze_req is deliberately not decoded here, so a
                        // repeated press never restarts the snooze period.
                        if (snooze_cnt == SNOOZE_LAST) begin
                            state      <= RINGING;
                            ring_cnt   <= '0;
                            snooze_cnt <= '0;
                            phase      <= 1'b1;
                            ringing    <= 1'b1;
                            snoozing   <= 1'b0;
                            buzzer     <= 1'b1;
                        end else begin
                            snooze_cnt <= snooze_cnt - SNOOZE_W'(1);
                        end
                    end
                end

                default: begin
                    state      <= DISARMED;
                    ring_cnt   <= '0;
                    snooze_cnt <= '0;
                    phase      <= 1'b0;
                    armed      <= 1'b0;
                    ringing    <= 1'b0;
                    snoozing   <= 1'b0;
                    buzzer     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl
//   Self-checking bench for alarm_ctrl: a table of single-cycle vectors,
//   hand-written multi-cycle sequences (edit wrap, ring timeout, snooze,
//   priority, hold-at-match, reset mid-snooze) and a randomized run against
//   a behavioural model that keeps time as plain integers.
module tb_alarm_ctrl;

    localparam int unsigned RING_T = 60;
    localparam int unsigned SNZ_M  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1s = 1'b0;
    logic [3:0] bcd_H1 = '0, bcd_H2 = '0, bcd_M1 = '0, bcd_M2 = '0, bcd_S1 = '0, bcd_S2 = '0;
    logic       arm_toggle = 1'b0;
    logic       snooze_req = 1'b0;
    logic       stop_req = 1'b0;
    logic [1:0] set_sel = 2'b00;
    logic       set_inc = 1'b0;
    logic [3:0] alarm_H1, alarm_H2, alarm_M1, alarm_M2;
    logic       armed, ringing, snoozing, buzzer;

    int n_pass = 0;
    int n_total = 0;

    alarm_ctrl #(
        .RING_TIMEOUT_S(RING_T),
        .SNOOZE_MIN    (SNZ_M),
        .ALARM_RST_H   (8'h06),
        .ALARM_RST_M   (8'h00)
    ) dut (
        .clk(clk), .rst(rst), .tick_1s(tick_1s),
        .bcd_H1(bcd_H1), .bcd_H2(bcd_H2), .bcd_M1(bcd_M1),
        .bcd_M2(bcd_M2), .bcd_S1(bcd_S1), .bcd_S2(bcd_S2),
        .arm_toggle(arm_toggle), .snooze_req(snooze_req), .stop_req(stop_req),
        .set_sel(set_sel), .set_inc(set_inc),
        .alarm_H1(alarm_H1), .alarm_H2(alarm_H2), .alarm_M1(alarm_M1), .alarm_M2(alarm_M2),
        .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit       rst, tick, arm, snz, stp, inc;
        bit [1:0] sel;
        int       hh, mm, ss;
        bit       e_armed, e_ring, e_snz, e_buz;
        int       e_alarm;  // HHMM as decimal
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit t, bit a, bit sn, bit st, bit [1:0] sel, bit inc,
                                int hh, int mm, int ss,
                                bit ea, bit er, bit es, bit eb, int eal);
        vec_t v;
        v.rst = r; v.tick = t; v.arm = a; v.snz = sn; v.stp = st; v.sel = sel; v.inc = inc;
        v.hh = hh; v.mm = mm; v.ss = ss;
        v.e_armed = ea; v.e_ring = er; v.e_snz = es; v.e_buz = eb; v.e_alarm = eal;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int alarm_val();
        return int'(alarm_H1) * 1000 + int'(alarm_H2) * 100 + int'(alarm_M1) * 10 + int'(alarm_M2);
    endfunction

    task automatic check_outs(input string tag, input bit ea, input bit er, input bit es,
                              input bit eb, input int eal);
        chk({tag, ".armed"},    int'(armed),    int'(ea));
        chk({tag, ".ringing"},  int'(ringing),  int'(er));
        chk({tag, ".snoozing"}, int'(snoozing), int'(es));
        chk({tag, ".buzzer"},   int'(buzzer),   int'(eb));
        chk({tag, ".alarm"},    alarm_val(),    eal);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bcd_H1 = 4'(h / 10); bcd_H2 = 4'(h % 10);
        bcd_M1 = 4'(m / 10); bcd_M2 = 4'(m % 10);
        bcd_S1 = 4'(s / 10); bcd_S2 = 4'(s % 10);
    endtask

    // One clock: inputs already driven, sample #1 after the edge, then
    // drop all one-cycle pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst = 1'b0; tick_1s = 1'b0; arm_toggle = 1'b0; snooze_req = 1'b0;
        stop_req = 1'b0; set_inc = 1'b0;
    endtask

    task automatic do_reset();
        set_sel = 2'b00;
        set_time(12, 34, 56);
        rst = 1'b1;
        cycle();
    endtask

    // From ARMED with alarm 06:00: leave the match second, then re-enter it.
    task automatic start_ring();
        set_time(6, 0, 1);
        cycle();
        set_time(6, 0, 0);
        cycle();
    endtask

    // Behavioural model state
    int m_alarm_min;
    bit m_armed, m_ring, m_snz, m_beep, m_prev_match;
    int m_ring_secs, m_snz_left;

    task automatic model_reset();
        m_alarm_min = 6 * 60;
        m_armed = 0; m_ring = 0; m_snz = 0; m_beep = 0; m_prev_match = 0;
        m_ring_secs = 0; m_snz_left = 0;
    endtask

    task automatic model_start_ring();
        m_ring = 1; m_snz = 0; m_armed = 1; m_ring_secs = 0; m_snz_left = 0; m_beep = 1;
    endtask

    task automatic model_idle(input bit keep_armed);
        m_armed = keep_armed; m_ring = 0; m_snz = 0; m_beep = 0;
        m_ring_secs = 0; m_snz_left = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit a, input bit sn, input bit st,
                              input bit [1:0] sel, input bit inc, input int h, input int m, input int s);
        bit mt, ev;
        if (r) begin
            model_reset();
            return;
        end
        mt = (h * 60 + m == m_alarm_min) && (s == 0);
        ev = mt && !m_prev_match;
        m_prev_match = mt;
        if (inc && sel == 2'b01)
            m_alarm_min = ((m_alarm_min / 60 + 1) % 24) * 60 + m_alarm_min % 60;
        else if (inc && sel == 2'b10)
            m_alarm_min = (m_alarm_min / 60) * 60 + (m_alarm_min % 60 + 1) % 60;
        if (!m_armed) begin
            if (a) m_armed = 1;
        end else if (m_ring) begin
            if (a) model_idle(0);
            else if (st) model_idle(1);
            else if (sn) begin
                m_ring = 0; m_snz = 1; m_beep = 0; m_ring_secs = 0;
                m_snz_left = SNZ_M * 60;
            end else if (t) begin
                m_ring_secs++;
                if (m_ring_secs == RING_T) model_idle(1);
                else m_beep = !m_beep;
            end
        end else if (m_snz) begin
            if (a) model_idle(0);
            else if (st) model_idle(1);
            else if (t) begin
                m_snz_left--;
                if (m_snz_left == 0) model_start_ring();
            end
        end else begin
            if (a) m_armed = 0;
            else if (ev) model_start_ring();
        end
    endtask

    initial begin
        int edges;
        bit prev_r;
        bit seen;

        // ---------------- table-driven vectors ----------------
        //           rst t a sn st sel inc  hh mm ss   A R S B  alarm
        vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 0, 12, 34, 56, 0, 0, 0, 0, 600));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 12, 34, 56, 1, 0, 0, 0, 600));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0,  6,  0,  0, 1, 1, 0, 1, 600));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'd0, 0,  6,  0,  0, 1, 1, 0, 0, 600));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'd0, 0, 12, 34, 56, 1, 1, 0, 1, 600));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'd0, 0, 12, 34, 56, 1, 0, 1, 0, 600));
        vecs.push_back(mk(0, 1, 0, 1, 0, 2'd0, 0, 12, 34, 56, 1, 0, 1, 0, 600));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2'd0, 0, 12, 34, 56, 1, 0, 0, 0, 600));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0, 12, 34, 56, 0, 0, 0, 0, 600));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd1, 1, 12, 34, 56, 0, 0, 0, 0, 700));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd2, 1, 12, 34, 56, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd3, 1, 12, 34, 56, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0,  7,  1,  0, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0,  7,  1,  0, 1, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, 12,  0,  0, 1, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0,  7,  1,  0, 1, 1, 0, 1, 701));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2'd0, 0,  7,  1,  0, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0,  7,  1,  0, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 1,  7,  1,  0, 0, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd0, 0,  7,  1,  0, 1, 0, 0, 0, 701));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd2, 1,  7,  2,  0, 1, 0, 0, 0, 702));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0,  7,  2,  0, 1, 1, 0, 1, 702));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; tick_1s = vecs[i].tick; arm_toggle = vecs[i].arm;
            snooze_req = vecs[i].snz; stop_req = vecs[i].stp;
            set_sel = vecs[i].sel; set_inc = vecs[i].inc;
            set_time(vecs[i].hh, vecs[i].mm, vecs[i].ss);
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_ring,
                       vecs[i].e_snz, vecs[i].e_buz, vecs[i].e_alarm);
        end

        // ---------------- edit wrap ----------------
        do_reset();
        set_sel = 2'b01;
        repeat (17) begin set_inc = 1'b1; cycle(); end
        chk("hour_23", alarm_val(), 2300);
        set_inc = 1'b1; cycle();
        chk("hour_wrap_00", alarm_val(), 0);
        set_inc = 1'b1; cycle();
        chk("hour_19_pulses", alarm_val(), 100);
        set_sel = 2'b10;
        repeat (59) begin set_inc = 1'b1; cycle(); end
        chk("min_59", alarm_val(), 159);
        set_inc = 1'b1; cycle();
        chk("min_wrap_00_no_carry", alarm_val(), 100);
        set_inc = 1'b1; cycle();
        chk("min_61_pulses", alarm_val(), 101);

        // ---------------- ring and timeout ----------------
        do_reset();
        arm_toggle = 1'b1; cycle();
        chk("arm_after_toggle", int'(armed), 1);
        start_ring();
        check_outs("ring_start", 1, 1, 0, 1, 600);
        for (int k = 1; k < int'(RING_T); k++) begin
            tick_1s = 1'b1; cycle();
            chk($sformatf("ring_buz_t%0d", k), int'(buzzer), int'(k % 2 == 0));
        end
        chk("ring_before_timeout", int'(ringing), 1);
        tick_1s = 1'b1; cycle();
        check_outs("ring_timeout", 1, 0, 0, 0, 600);

        // ---------------- snooze for SNZ_M minutes ----------------
        start_ring();
        snooze_req = 1'b1; cycle();
        check_outs("snooze_enter", 1, 0, 1, 0, 600);
        snooze_req = 1'b1; tick_1s = 1'b1; cycle();   // repeated press: counts as tick only
        repeat (SNZ_M * 60 - 2) begin tick_1s = 1'b1; cycle(); end
        check_outs("snooze_last_sec", 1, 0, 1, 0, 600);
        tick_1s = 1'b1; cycle();
        check_outs("snooze_expire", 1, 1, 0, 1, 600);
        repeat (RING_T - 1) begin tick_1s = 1'b1; cycle(); end
        chk("re_ring_cnt_restarted", int'(ringing), 1);
        tick_1s = 1'b1; cycle();
        check_outs("re_ring_timeout", 1, 0, 0, 0, 600);

        // ---------------- arm_toggle beats stop_req ----------------
        start_ring();
        arm_toggle = 1'b1; stop_req = 1'b1; cycle();
        check_outs("arm_over_stop", 0, 0, 0, 0, 600);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick_1s = (c % 10 == 0); cycle();
            if (ringing || armed) seen = 1;
        end
        chk("no_retrigger_disarmed", int'(seen), 0);

        // ---------------- disarmed: time passes through alarm ----------------
        seen = 0;
        for (int s = 57; s < 63; s++) begin
            set_time(s < 60 ? 5 : 6, s < 60 ? 59 : 0, s % 60);
            tick_1s = 1'b1; cycle();
            cycle();
            if (ringing) seen = 1;
        end
        chk("disarmed_pass_no_ring", int'(seen), 0);

        // ---------------- armed, time held at match ----------------
        set_time(12, 0, 0);
        arm_toggle = 1'b1; cycle();
        set_time(6, 0, 0);
        edges = 0; prev_r = 0;
        for (int c = 0; c < 300; c++) begin
            tick_1s = (c % 50 == 49); cycle();
            if (ringing && !prev_r) edges++;
            prev_r = ringing;
        end
        chk("held_match_one_entry", edges, 1);
        stop_req = 1'b1; cycle();
        check_outs("held_stop", 1, 0, 0, 0, 600);
        seen = 0;
        repeat (100) begin cycle(); if (ringing) seen = 1; end
        chk("held_stop_no_retrigger", int'(seen), 0);

        // ---------------- reset during snooze ----------------
        start_ring();
        snooze_req = 1'b1; cycle();
        repeat (5) begin tick_1s = 1'b1; cycle(); end
        set_sel = 2'b01; set_inc = 1'b1; cycle();
        check_outs("snooze_edit", 1, 0, 1, 0, 700);
        rst = 1'b1; cycle();
        check_outs("rst_in_snooze", 0, 0, 0, 0, 600);

        // ---------------- randomized run against model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 20000; c++) begin
            int h, m, s, sel_r;
            bit r, t, a, sn, st, inc;
            sel_r = $urandom_range(3, 0);
            case ($urandom_range(2, 0))
                0: begin h = m_alarm_min / 60; m = m_alarm_min % 60; s = 0; end
                1: begin h = m_alarm_min / 60; m = m_alarm_min % 60; s = $urandom_range(2, 0); end
                default: begin h = $urandom_range(23, 0); m = $urandom_range(59, 0); s = $urandom_range(59, 0); end
            endcase
            r   = ($urandom_range(1999, 0) == 0);
            t   = ($urandom_range(2, 0) == 0);
            a   = ($urandom_range(199, 0) == 0);
            st  = ($urandom_range(199, 0) == 0);
            sn  = ($urandom_range(149, 0) == 0);
            inc = ($urandom_range(59, 0) == 0);
            rst = r; tick_1s = t; arm_toggle = a; stop_req = st; snooze_req = sn;
            set_sel = 2'(sel_r); set_inc = inc;
            set_time(h, m, s);
            model_step(r, t, a, sn, st, 2'(sel_r), inc, h, m, s);
            cycle();
            check_outs($sformatf("rnd%0d", c), m_armed, m_ring, m_snz, m_ring && m_beep,
                       (m_alarm_min / 60) * 100 + m_alarm_min % 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm controller for the digital clock. Holds a user-settable HH:MM alarm time in BCD and compares it against the running 6-digit BCD time. When armed and the time matches, it sequences the alarm through ringing, snooze and timeout phases. Sits beside the BCD time counter; takes the 1 s pulse, the debounced key pulses and the set-field select from the clock state machine, and drives a buzzer line plus alarm digits for the display mux.

Parameters:
RING_TIMEOUT_S, 60, seconds of continuous ringing before auto-stop (range 2..255)
SNOOZE_MIN, 5, snooze length in minutes (range 1..9)
ALARM_RST_H, 8'h06, BCD hour loaded at reset ({H1,H2})
ALARM_RST_M, 8'h00, BCD minute loaded at reset ({M1,M2})

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
tick_1s  in  1  one-cycle pulse once per second
bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2  in  4 each  current time; *1 = tens digit, *2 = units digit
arm_toggle  in  1  one-cycle key pulse; toggles armed/disarmed
snooze_req  in  1  one-cycle key pulse; requests snooze
stop_req  in  1  one-cycle key pulse; silences the alarm and keeps it armed
set_sel  in  2  00 = no edit, 01 = edit hours, 10 = edit minutes, 11 = ignored
set_inc  in  1  one-cycle pulse; increments the selected field
alarm_H1, alarm_H2, alarm_M1, alarm_M2  out  4 each  stored alarm time (BCD)
armed  out  1  high in ARMED, RINGING and SNOOZE
ringing  out  1  high in RINGING
snoozing  out  1  high in SNOOZE
buzzer  out  1  beep pattern output

Behaviour:
- Reset (rst high at a clk edge): state DISARMED, alarm regs = ALARM_RST_H/M, ring_cnt = 0, snooze_cnt = 0, phase = 0, match_q = 0. All status outputs 0.
- Alarm edit:
  - Processed in every state. set_inc with set_sel = 01 increments hours 00..23 with BCD carry (09 -> 10, 23 -> 00).
  - set_sel = 10 increments minutes 00..59 (59 -> 00, no carry into hours).
  - set_sel = 00 or 11: no change.
  - The edited value is visible on the outputs in the next cycle.
- Match detection:
  - match = (bcd_H1,H2,M1,M2 == alarm regs) and (bcd_S1,S2 == 0,0). Compares raw 4-bit values.
  - match_q is a registered copy of match. match_event = match and not match_q, so there is exactly one event per matching second.
  - An edit that makes the alarm equal the current time at :00 also produces an event.
- FSM states: DISARMED, ARMED, RINGING, SNOOZE. Simultaneous-event priority: arm_toggle > stop_req > snooze_req > tick_1s / match_event.
  - DISARMED: arm_toggle -> ARMED. All other inputs ignored.
  - ARMED: arm_toggle -> DISARMED. match_event -> RINGING.
  - RINGING:
    - arm_toggle -> DISARMED.
    - stop_req -> ARMED.
    - snooze_req -> SNOOZE, loading snooze_cnt = SNOOZE_MIN*60.
    - tick_1s increments ring_cnt and toggles phase.
    - tick_1s while ring_cnt == RING_TIMEOUT_S-1 -> ARMED (timeout).
    - match_event is ignored.
  - SNOOZE:
    - arm_toggle -> DISARMED.
    - stop_req -> ARMED.
    - snooze_req is ignored (no restart).
    - tick_1s decrements snooze_cnt. tick_1s while snooze_cnt == 1 -> RINGING.
    - match_event is ignored.
- Entering RINGING from any state: ring_cnt = 0, phase = 1.
- Leaving RINGING/SNOOZE: ring_cnt, snooze_cnt and phase are cleared.
- buzzer = ringing and phase, registered. The pattern is 1 s on / 1 s off, starting on.
- Latency: every output changes one clk after the causing input cycle (all outputs registered). Example: match_event detected in cycle n gives ringing = buzzer = 1 at cycle n+1.
- Counter widths: ring_cnt = $clog2(RING_TIMEOUT_S). snooze_cnt = $clog2(SNOOZE_MIN*60+1). No wrap can occur inside the legal parameter ranges.
- rst asserted mid-ring or mid-snooze: returns to DISARMED next edge, buzzer 0; alarm time returns to reset values.

Test Plan:
- Reset, arm_toggle, drive time 06:00:00 -> armed=1 after the toggle; one cycle after match, ringing=1 and buzzer=1. buzzer toggles on each tick_1s. After 60 ticks: ringing=0, armed=1.
- set_sel=01 with 19 set_inc pulses from 06 -> alarm hours 01 (23 -> 00 wrap checked). set_sel=10 with 61 pulses from 00 -> minutes 01.
- Ringing, then snooze_req -> snoozing=1, buzzer=0. After exactly 300 ticks -> ringing=1 again, buzzer=1, ring_cnt restarted.
- Ringing with arm_toggle and stop_req in the same cycle -> DISARMED (armed=0). Time held at 06:00:00 for further cycles -> no re-trigger.
- Disarmed state, time passes 06:00:00 -> ringing stays 0. Armed, time held at 06:00:00 for 50M cycles -> exactly one RINGING entry. stop_req then gives no retrigger within that second.
- rst pulsed during SNOOZE -> next cycle all outputs 0, alarm = 06:00.
